dadda_csa_pipe: RTL and testbench

//  Pipelined unsigned WIDTHxWIDTH multiplier front-end.
//  - Generates the AND partial-product array and reduces it with a Dadda tree to two rows, sum and carry.
//  - The rows feed the downstream carry-lookahead final adder (Adder32 for WIDTH=16, Adder16 for WIDTH=8) with carry-in 0.
//  - Two register stages with a valid/ready handshake give one product per clock at full throughput.

---
 rtl/dadda_csa_pipe.sv | 178 +++++++++++++++++
 tb/tb_dadda_csa_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_csa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dadda_csa_pipe
// Description : Two-stage pipelined unsigned multiplier front-end. AND array
//               reduced by a Dadda tree to a carry-save sum/carry row pair.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_csa_pipe #(
  parameter  int WIDTH = 16,
  localparam int OUT_W = 2 * WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oValid,
  input  logic             iReady,
  output logic [OUT_W-1:0] oRowS,
  output logic [OUT_W-1:0] oRowC
);

  localparam int MAX_H = WIDTH;
  localparam int S1_H  = 6;

  generate
    if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
      $error("dadda_csa_pipe: WIDTH must be 8 or 16");
    end
  endgenerate

  typedef logic [OUT_W-1:0][MAX_H-1:0] col_t;
  typedef logic [OUT_W-1:0][7:0]       ht_t;
  typedef logic [OUT_W-1:0][S1_H-1:0]  s1_t;

  // One Dadda reduction step to column height d. Columns are walked LSB first
  // so that carries from column j-1 are already counted when column j is sized.
  function automatic void dadda_step(input int d, inout col_t cols, inout ht_t hts);
    col_t nc;
    ht_t  nh;
    int   r;
    int   p;
    int   n;
    nc = '0;
    nh = '0;
    for (int j = 0; j < OUT_W; j++) begin
      r = int'(hts[j]);
      p = 0;
      n = int'(nh[j]);
      for (int it = 0; it < MAX_H; it++) begin
        if (r + n > d) begin
          if (r + n - d == 1) begin
            nc[j][n] = cols[j][p] ^ cols[j][p+1];
            if (j + 1 < OUT_W) begin
              nc[j+1][nh[j+1]] = cols[j][p] & cols[j][p+1];
              nh[j+1] = nh[j+1] + 8'd1;
            end
            p = p + 2;
            r = r - 2;
          end else begin
            nc[j][n] = cols[j][p] ^ cols[j][p+1] ^ cols[j][p+2];
            if (j + 1 < OUT_W) begin
              nc[j+1][nh[j+1]] = (cols[j][p] & cols[j][p+1]) |
                                 (cols[j][p+2] & (cols[j][p] ^ cols[j][p+1]));
              nh[j+1] = nh[j+1] + 8'd1;
            end
            p = p + 3;
            r = r - 3;
          end
          n = n + 1;
        end
      end
      for (int k = 0; k < MAX_H; k++) begin
        if (k < r && n + k < MAX_H) begin
          nc[j][n+k] = cols[j][p+k];
        end
      end
      nh[j] = 8'(n + r);
    end
    cols = nc;
    hts  = nh;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_cols_q, s1_cols_d;
  s1_t              s1_comb;
  ht_t              s1_hts;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] row_s_q, row_s_d, row_c_q, row_c_d;
  logic [OUT_W-1:0] row_s_comb, row_c_comb;
  logic             s2_adv, s1_adv;

  // Stage 1: partial products, then 16->13->9->6 (or 8->6).
  always_comb begin
    col_t c;
    ht_t  h;
    c = '0;
    h = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        c[i+j][h[i+j]] = iA[j] & iB[i];
        h[i+j] = h[i+j] + 8'd1;
      end
    end
    if (WIDTH > 13) dadda_step(13, c, h);
    if (WIDTH > 9)  dadda_step(9, c, h);
    if (WIDTH > 6)  dadda_step(6, c, h);
    for (int j = 0; j < OUT_W; j++) begin
      s1_comb[j] = c[j][S1_H-1:0];
    end
    s1_hts = h;
  end

  // Stage 2: registered columns 6->4->3->2. The height map is pure elaboration
  // structure, so reusing the stage-1 result here adds no real path.
  always_comb begin
    col_t c;
    ht_t  h;
    c = '0;
    h = s1_hts;
    for (int j = 0; j < OUT_W; j++) begin
      c[j][S1_H-1:0] = s1_cols_q[j];
    end
    dadda_step(4, c, h);
    dadda_step(3, c, h);
    dadda_step(2, c, h);
    row_s_comb = '0;
    row_c_comb = '0;
    for (int j = 0; j < OUT_W; j++) begin
      row_s_comb[j] = c[j][0];
      row_c_comb[j] = c[j][1];
    end
  end

  assign s2_adv = !out_valid_q | iReady;
  assign s1_adv = !s1_valid_q | s2_adv;
  assign oReady = s1_adv & !iRst;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cols_d   = s1_cols_q;
    out_valid_d = out_valid_q;
    row_s_d     = row_s_q;
    row_c_d     = row_c_q;
    if (s1_adv) begin
      s1_valid_d = iValid & oReady;
      s1_cols_d  = s1_comb;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      row_s_d     = row_s_comb;
      row_c_d     = row_c_comb;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_valid_q  <= 1'b0;
      s1_cols_q   <= '0;
      out_valid_q <= 1'b0;
      row_s_q     <= '0;
      row_c_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cols_q   <= s1_cols_d;
      out_valid_q <= out_valid_d;
      row_s_q     <= row_s_d;
      row_c_q     <= row_c_d;
    end
  end

  assign oValid = out_valid_q;
  assign oRowS  = row_s_q;
  assign oRowC  = row_c_q;

endmodule
`default_nettype wire

// File: tb/tb_dadda_csa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_csa_pipe
// Description : Scoreboard bench for dadda_csa_pipe at WIDTH=16 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_csa_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        v16, r16, ordy16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] rs16, rc16;
  logic        v8, r8, ordy8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] rs8, rc8;
  wire  [31:0] sum16 = rs16 + rc16;
  wire  [15:0] sum8  = rs8 + rc8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dadda_csa_pipe #(.WIDTH(16)) u_dut16 (
    .iClk(clk), .iRst(rst), .iValid(v16), .oReady(ordy16), .iA(a16), .iB(b16),
    .oValid(ov16), .iReady(r16), .oRowS(rs16), .oRowC(rc16)
  );

  dadda_csa_pipe #(.WIDTH(8)) u_dut8 (
    .iClk(clk), .iRst(rst), .iValid(v8), .oReady(ordy8), .iA(a8), .iB(b8),
    .oValid(ov8), .iReady(r8), .oRowS(rs8), .oRowC(rc8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: push on accept, pop on consume, both judged at the negedge.
  logic [31:0] q16[$];
  logic [15:0] q8[$];
  int          out16 = 0;

  initial begin
    logic        stall;
    logic [31:0] ps, pc, e, p;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q16.delete();
        stall = 1'b0;
      end else begin
        if (ov16 && r16) begin
          out16++;
          if (q16.size() == 0) chk("unexpected_out16", 64'(sum16), 64'hDEAD);
          else begin
            e = q16.pop_front();
            chk("prod16", 64'(sum16), 64'(e));
          end
        end
        if (stall) begin
          chk("stable_s16", 64'(rs16), 64'(ps));
          chk("stable_c16", 64'(rc16), 64'(pc));
        end
        stall = ov16 && !r16;
        ps = rs16;
        pc = rc16;
        if (v16 && ordy16) begin
          p = 32'(a16) * 32'(b16);
          q16.push_back(p);
        end
      end
    end
  end

  initial begin
    logic        stall;
    logic [15:0] ps, pc, e, p;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q8.delete();
        stall = 1'b0;
      end else begin
        if (ov8 && r8) begin
          if (q8.size() == 0) chk("unexpected_out8", 64'(sum8), 64'hDEAD);
          else begin
            e = q8.pop_front();
            chk("prod8", 64'(sum8), 64'(e));
          end
        end
        if (stall) begin
          chk("stable_s8", 64'(rs8), 64'(ps));
          chk("stable_c8", 64'(rc8), 64'(pc));
        end
        stall = ov8 && !r8;
        ps = rs8;
        pc = rc8;
        if (v8 && ordy8) begin
          p = 16'(a8) * 16'(b8);
          q8.push_back(p);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    logic acc;
    acc = 1'b0;
    a16 = a;
    b16 = b;
    v16 = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = ordy16;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send16_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    v16 = 1'b0;
    v8  = 1'b0;
    r16 = 1'b1;
    r8  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (q16.size() == 0 && q8.size() == 0) break;
    end
    chk("drain_q16_empty", 64'(q16.size()), 64'd0);
    chk("drain_q8_empty", 64'(q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    v16 = 1'b0; r16 = 1'b1; a16 = '0; b16 = '0;
    v8  = 1'b0; r8  = 1'b1; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 64'(ordy16), 64'd0);
    chk("rst_valid", 64'(ov16), 64'd0);
    chk("rst_rows", 64'({rs16, rc16}), 64'd0);
    chk("rst_valid8", 64'(ov8), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ordy16), 64'd1);
    @(posedge clk);
    #1;

    // T1: all-ones operands, two-edge latency
    send16(16'hFFFF, 16'hFFFF);
    v16 = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_valid", 64'(ov16), 64'd1);
    chk("t1_sum", 64'(sum16), 64'hFFFE0001);
    drain();

    // T2: eight back-to-back operands with no bubbles
    base = out16;
    send16(16'h0001, 16'h0001);
    send16(16'h00FF, 16'h0101);
    send16(16'h1111, 16'h2222);
    send16(16'hABCD, 16'h0002);
    send16(16'h7FFF, 16'hFFFF);
    send16(16'h0100, 16'h0100);
    send16(16'hFFFF, 16'h0001);
    send16(16'h1234, 16'h5678);
    v16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t2_count", 64'(out16 - base), 64'd8);
    chk("t2_last", 64'(sum16), 64'h06260060);
    drain();

    // T3: downstream stall fills both stages, then release
    r16 = 1'b0;
    send16(16'h0003, 16'h0007);
    send16(16'h0102, 16'h0304);
    a16 = 16'hBEEF;
    b16 = 16'h1001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_ready_low", 64'(ordy16), 64'd0);
      @(posedge clk);
      #1;
    end
    r16 = 1'b1;
    @(negedge clk);
    chk("t3_ready_rise", 64'(ordy16), 64'd1);
    @(posedge clk);
    #1;
    drain();

    // T4: reset with both stages full discards everything
    r16 = 1'b0;
    send16(16'h0011, 16'h0022);
    send16(16'h0033, 16'h0044);
    v16 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_ready_in_rst", 64'(ordy16), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r16 = 1'b1;
    @(negedge clk);
    chk("t4_valid_cleared", 64'(ov16), 64'd0);
    chk("t4_rows_cleared", 64'({rs16, rc16}), 64'd0);
    @(posedge clk);
    #1;
    send16(16'h0003, 16'h0005);
    v16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_valid_after", 64'(ov16), 64'd1);
    chk("t4_sum_after", 64'(sum16), 64'd15);
    drain();

    // T5: zero operands and MSB-only operands
    send16(16'h0000, 16'h1234);
    send16(16'hABCD, 16'h0000);
    send16(16'h8000, 16'h8000);
    v16 = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_msb_sum", 64'(sum16), 64'h40000000);
    drain();

    // T6: random traffic on both widths
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          a16 = 16'($urandom);
          b16 = 16'($urandom);
          v16 = ($urandom_range(2) != 0);
          r16 = ($urandom_range(3) != 0);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int k = 0; k < 3000; k++) begin
          a8 = 8'($urandom);
          b8 = 8'($urandom);
          v8 = ($urandom_range(2) != 0);
          r8 = ($urandom_range(3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
